// File: rtl/multi_cycle_control_unit.sv
// rtl/multi_cycle_control_unit.sv - multi-cycle RV32I control FSM with memory handshake, stall timeout and counters
// Sequences IF/ID/EX/MEM/WB and drives the datapath strobes for the current state.
module multi_cycle_control_unit #(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             halt_cond,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             pc_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  // Wide enough to hold MEM_WAIT_MAX+1 so the limit compare never aliases.
  localparam int STALL_W = $clog2(MEM_WAIT_MAX + 2);

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic               mem_phase;
  logic               timeout;
  logic               is_load;
  logic               goes_to_ex;

  assign is_load    = (opcode == OP_LD);
  assign goes_to_ex = (opcode == OP_R)  || (opcode == OP_I)   || (opcode == OP_LD) ||
                      (opcode == OP_ST) || (opcode == OP_BR)  || (opcode == OP_JAL) ||
                      (opcode == OP_JALR);
  assign mem_phase  = (state_q == S_IF) || (state_q == S_MEM);
  assign timeout    = (MEM_WAIT_MAX > 0) && mem_phase && !mem_ready &&
                      ((32'(stall_q) + 32'd1) >= 32'(MEM_WAIT_MAX));

  always_comb begin
    state_d       = state_q;
    mem_err_d     = mem_err_q;
    stall_d       = '0;
    retire        = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    pc_to_reg     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        if (opcode == OP_SYS && halt_cond) begin
          state_d = S_HALT;
        end else if (goes_to_ex) begin
          state_d = S_EX;
        end else begin
          // ECALL without the halt qualifier and unknown opcodes retire as NOPs.
          pc_write = 1'b1;
          retire   = 1'b1;
          state_d  = S_IF;
        end
      end
      S_EX: begin
        case (opcode)
          OP_R, OP_I: begin
            alu_src_a = 1'b1;
            alu_src_b = (opcode == OP_I) ? 2'b10 : 2'b00;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          OP_LD, OP_ST: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
          OP_BR: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            retire        = 1'b1;
            state_d       = S_IF;
          end
          OP_JAL, OP_JALR: begin
            reg_write = 1'b1;
            pc_to_reg = 1'b1;
            pc_write  = 1'b1;
            pc_source = (opcode == OP_JAL) ? 2'b01 : 2'b10;
            retire    = 1'b1;
            state_d   = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = is_load;
        mem_write = !is_load;
        if (mem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_IF;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_d    = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    if (mem_phase && !mem_ready && stall_q != '1) begin
      stall_d = stall_q + STALL_W'(1);
    end else if (mem_phase && !mem_ready) begin
      stall_d = stall_q;
    end

    if (timeout) begin
      state_d   = S_HALT;
      mem_err_d = 1'b1;
    end
  end

  assign cycle_d   = (state_q != S_HALT) ? cycle_q + CNT_W'(1) : cycle_q;
  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      stall_q   <= '0;
      mem_err_q <= 1'b0;
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      mem_err_q <= mem_err_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
    end
  end

  assign halted        = (state_q == S_HALT);
  assign mem_err       = mem_err_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb/tb_multi_cycle_control_unit.sv - randomized self-checking bench for multi_cycle_control_unit
// Expected strobes come from per-instruction traces built from the instruction-class rules.
module tb_multi_cycle_control_unit;

  typedef struct packed {
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
  } strb_t;

  typedef struct packed {
    logic  rdy;
    logic  fetch;
    logic  retire;
    logic  to_halt;
    logic  to_err;
    strb_t exp;
  } step_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_NOP  = 7'b0000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v = 2'b11;
  logic [1:0] rdy_v = 2'b00;
  logic [1:0] hc_v  = 2'b00;
  logic [6:0] op_a  = 7'd0;
  logic [6:0] op_b  = 7'd0;

  logic a_ir, a_iod, a_mr, a_mw, a_m2r, a_p2r, a_rw, a_asa, a_pw, a_pwc, halt_a, err_a;
  logic [1:0] a_asb, a_aop, a_ps;
  logic [31:0] cyc_a, ret_a;
  logic b_ir, b_iod, b_mr, b_mw, b_m2r, b_p2r, b_rw, b_asa, b_pw, b_pwc, halt_b, err_b;
  logic [1:0] b_asb, b_aop, b_ps;
  logic [3:0] cyc_b, ret_b;
  strb_t obs_a, obs_b;

  assign obs_a = {a_ir, a_iod, a_mr, a_mw, a_m2r, a_p2r, a_rw, a_asa, a_asb, a_aop, a_pw, a_pwc, a_ps};
  assign obs_b = {b_ir, b_iod, b_mr, b_mw, b_m2r, b_p2r, b_rw, b_asa, b_asb, b_aop, b_pw, b_pwc, b_ps};

  multi_cycle_control_unit #(.CNT_W(32), .MEM_WAIT_MAX(0)) dut_a (
    .clk(clk), .reset(rst_v[0]), .opcode(op_a), .mem_ready(rdy_v[0]), .halt_cond(hc_v[0]),
    .ir_write(a_ir), .i_or_d(a_iod), .mem_read(a_mr), .mem_write(a_mw), .mem_to_reg(a_m2r),
    .pc_to_reg(a_p2r), .reg_write(a_rw), .alu_src_a(a_asa), .alu_src_b(a_asb), .alu_op(a_aop),
    .pc_write(a_pw), .pc_write_cond(a_pwc), .pc_source(a_ps), .halted(halt_a), .mem_err(err_a),
    .cycle_count(cyc_a), .retired_count(ret_a)
  );

  multi_cycle_control_unit #(.CNT_W(4), .MEM_WAIT_MAX(4)) dut_b (
    .clk(clk), .reset(rst_v[1]), .opcode(op_b), .mem_ready(rdy_v[1]), .halt_cond(hc_v[1]),
    .ir_write(b_ir), .i_or_d(b_iod), .mem_read(b_mr), .mem_write(b_mw), .mem_to_reg(b_m2r),
    .pc_to_reg(b_p2r), .reg_write(b_rw), .alu_src_a(b_asa), .alu_src_b(b_asb), .alu_op(b_aop),
    .pc_write(b_pw), .pc_write_cond(b_pwc), .pc_source(b_ps), .halted(halt_b), .mem_err(err_b),
    .cycle_count(cyc_b), .retired_count(ret_b)
  );

  int          sel;
  int          n_checks;
  int          n_fail;
  int unsigned exp_cyc;
  int unsigned exp_ret;
  bit          exp_halt;
  bit          exp_err;
  step_t       tr[$];

  function automatic strb_t cur_obs();
    return (sel == 0) ? obs_a : obs_b;
  endfunction
  function automatic logic [31:0] cur_cyc();
    return (sel == 0) ? cyc_a : {28'd0, cyc_b};
  endfunction
  function automatic logic [31:0] cur_ret();
    return (sel == 0) ? ret_a : {28'd0, ret_b};
  endfunction
  function automatic logic [1:0] cur_flags();
    return (sel == 0) ? {halt_a, err_a} : {halt_b, err_b};
  endfunction
  function automatic logic [31:0] cur_mask();
    return (sel == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction
  function automatic int wmax();
    return (sel == 0) ? 0 : 4;
  endfunction

  task automatic drive(input logic rdy, input logic [6:0] op, input logic hc);
    if (sel == 0) begin rdy_v[0] = rdy; op_a = op; hc_v[0] = hc; end
    else begin rdy_v[1] = rdy; op_b = op; hc_v[1] = hc; end
  endtask

  task automatic set_rst(input logic r);
    if (sel == 0) rst_v[0] = r;
    else rst_v[1] = r;
  endtask

  task automatic push(input logic rdy, input logic fetch, input logic ret, input logic th,
                      input logic te, input strb_t s);
    step_t st;
    st.rdy = rdy; st.fetch = fetch; st.retire = ret; st.to_halt = th; st.to_err = te; st.exp = s;
    tr.push_back(st);
  endtask

  // A memory access: stall cycles hold the base strobes, the ready cycle adds the completion strobes.
  task automatic mem_access(input strb_t base, input strb_t done, input logic fetch, input int stalls,
                            input logic ret, output bit aborted);
    aborted = 1'b0;
    for (int k = 0; k < stalls; k++) begin
      if (wmax() > 0 && k + 1 >= wmax()) begin
        push(1'b0, fetch, 1'b0, 1'b1, 1'b1, base);
        aborted = 1'b1;
        return;
      end
      push(1'b0, fetch, 1'b0, 1'b0, 1'b0, base);
    end
    push(1'b1, fetch, ret, 1'b0, 1'b0, strb_t'(base | done));
  endtask

  task automatic build(input logic [6:0] op, input logic hc, input int ifs, input int mems);
    strb_t z, s, d;
    bit    ab;
    z = '0;
    tr.delete();
    s = z; s.mem_read = 1'b1;
    d = z; d.ir_write = 1'b1;
    mem_access(s, d, 1'b1, ifs, 1'b0, ab);
    if (ab) return;
    if (!(op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR})) begin
      s = z; s.pc_write = 1'b1;
      if (op == OP_SYS && hc) push(1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, z);
      else push(1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, s);
      return;
    end
    push(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, z);
    s = z;
    d = z; d.reg_write = 1'b1; d.pc_write = 1'b1;
    case (op)
      OP_R, OP_I: begin
        s.alu_src_a = 1'b1; s.alu_src_b = (op == OP_I) ? 2'b10 : 2'b00; s.alu_op = 2'b10;
        push(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, s);
        push(1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, d);
      end
      OP_LD, OP_ST: begin
        s.alu_src_a = 1'b1; s.alu_src_b = 2'b10;
        push(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, s);
        s = z; s.i_or_d = 1'b1;
        if (op == OP_LD) s.mem_read = 1'b1; else s.mem_write = 1'b1;
        d = z;
        if (op == OP_ST) d.pc_write = 1'b1;
        mem_access(s, d, 1'b0, mems, op == OP_ST, ab);
        if (!ab && op == OP_LD) begin
          d = z; d.reg_write = 1'b1; d.mem_to_reg = 1'b1; d.pc_write = 1'b1;
          push(1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, d);
        end
      end
      OP_BR: begin
        s.alu_src_a = 1'b1; s.alu_op = 2'b01; s.pc_write_cond = 1'b1; s.pc_source = 2'b01;
        push(1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, s);
      end
      default: begin
        s.reg_write = 1'b1; s.pc_to_reg = 1'b1; s.pc_write = 1'b1;
        s.pc_source = (op == OP_JAL) ? 2'b01 : 2'b10;
        push(1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, s);
      end
    endcase
  endtask

  // Plays the trace one cycle per step; starts and ends on a falling edge.
  task automatic run_trace(input logic [6:0] op, input logic hc);
    foreach (tr[i]) begin
      drive(tr[i].rdy, tr[i].fetch ? 7'($urandom) : op, hc);
      #1;
      n_checks++;
      if (cur_obs() !== tr[i].exp) begin
        n_fail++;
        $display("FAIL strobes dut=%0d op=%b step=%0d got=%h want=%h", sel, op, i, cur_obs(), tr[i].exp);
      end
      n_checks++;
      if (cur_flags() !== {exp_halt, exp_err}) begin
        n_fail++;
        $display("FAIL halted/mem_err dut=%0d op=%b step=%0d got=%b want=%b", sel, op, i, cur_flags(), {exp_halt, exp_err});
      end
      n_checks++;
      if (cur_cyc() !== (exp_cyc & cur_mask()) || cur_ret() !== (exp_ret & cur_mask())) begin
        n_fail++;
        $display("FAIL counters dut=%0d op=%b step=%0d got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                 sel, op, i, cur_cyc(), cur_ret(), exp_cyc & cur_mask(), exp_ret & cur_mask());
      end
      @(posedge clk);
      if (!exp_halt) exp_cyc++;
      if (tr[i].retire) exp_ret++;
      if (tr[i].to_halt) exp_halt = 1'b1;
      if (tr[i].to_err) exp_err = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic hc, input int ifs, input int mems);
    build(op, hc, ifs, mems);
    run_trace(op, hc);
  endtask

  task automatic run_halt(input int n);
    tr.delete();
    repeat (n) push(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, strb_t'(0));
    run_trace(OP_NOP, 1'($urandom));
  endtask

  task automatic do_reset();
    set_rst(1'b1);
    drive(1'b0, OP_R, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_rst(1'b0);
    exp_cyc = 0; exp_ret = 0; exp_halt = 1'b0; exp_err = 1'b0;
  endtask

  task automatic test_reset();
    strb_t f;
    f = '0; f.mem_read = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      drive(1'b0, OP_R, 1'b0);
      #1;
      n_checks++;
      if (cur_obs() !== f || cur_flags() !== 2'b00 || cur_cyc() !== 32'd0 || cur_ret() !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_state dut=%0d got strb=%h flags=%b cyc=%0d ret=%0d want strb=%h flags=00 cyc=0 ret=0",
                 s, cur_obs(), cur_flags(), cur_cyc(), cur_ret(), f);
      end
    end
    @(negedge clk);
    rst_v = 2'b00;
  endtask

  task automatic test_add();
    sel = 0; do_reset();
    run_instr(OP_R, 1'b0, 0, 0);
    n_checks++;
    if (ret_a !== 32'd1 || cyc_a !== 32'd4) begin
      n_fail++; $display("FAIL add_latency got ret=%0d cyc=%0d want ret=1 cyc=4", ret_a, cyc_a);
    end
  endtask

  task automatic test_load_stall();
    sel = 0; do_reset();
    run_instr(OP_LD, 1'b0, 0, 3);
    n_checks++;
    if (ret_a !== 32'd1 || cyc_a !== 32'd8) begin
      n_fail++; $display("FAIL load_stall got ret=%0d cyc=%0d want ret=1 cyc=8", ret_a, cyc_a);
    end
  endtask

  task automatic test_branch_jumps();
    sel = 0; do_reset();
    run_instr(OP_BR, 1'b0, 0, 0);
    run_instr(OP_JAL, 1'b0, 0, 0);
    run_instr(OP_JALR, 1'b0, 0, 0);
    run_instr(OP_I, 1'b0, 0, 0);
    run_instr(OP_ST, 1'b0, 0, 0);
    n_checks++;
    if (ret_a !== 32'd5 || cyc_a !== 32'd17) begin
      n_fail++; $display("FAIL branch_jump_latency got ret=%0d cyc=%0d want ret=5 cyc=17", ret_a, cyc_a);
    end
  endtask

  task automatic test_ecall();
    sel = 0; do_reset();
    run_instr(OP_SYS, 1'b0, 0, 0);
    run_instr(OP_SYS, 1'b1, 0, 0);
    run_halt(10);
    n_checks++;
    if (ret_a !== 32'd1 || cyc_a !== 32'd4 || halt_a !== 1'b1 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ecall_halt got ret=%0d cyc=%0d halted=%b err=%b want ret=1 cyc=4 halted=1 err=0",
               ret_a, cyc_a, halt_a, err_a);
    end
  endtask

  task automatic test_timeout();
    sel = 1; do_reset();
    run_instr(OP_R, 1'b0, 4, 0);
    run_halt(5);
    n_checks++;
    if (err_b !== 1'b1 || halt_b !== 1'b1 || cyc_b !== 4'd4 || ret_b !== 4'd0) begin
      n_fail++;
      $display("FAIL if_timeout got err=%b halted=%b cyc=%0d ret=%0d want err=1 halted=1 cyc=4 ret=0",
               err_b, halt_b, cyc_b, ret_b);
    end
    do_reset();
    run_instr(OP_R, 1'b0, 3, 0);
    n_checks++;
    if (err_b !== 1'b0 || ret_b !== 4'd1 || cyc_b !== 4'd7) begin
      n_fail++; $display("FAIL at_limit_ok got err=%b ret=%0d cyc=%0d want err=0 ret=1 cyc=7", err_b, ret_b, cyc_b);
    end
    do_reset();
    run_instr(OP_ST, 1'b0, 0, 4);
    run_halt(3);
    n_checks++;
    if (err_b !== 1'b1 || cyc_b !== 4'd7) begin
      n_fail++; $display("FAIL mem_timeout got err=%b cyc=%0d want err=1 cyc=7", err_b, cyc_b);
    end
    do_reset();
    run_instr(OP_LD, 1'b0, 0, 3);
  endtask

  task automatic test_reset_mid_store();
    strb_t f;
    f = '0; f.mem_read = 1'b1;
    sel = 0; do_reset();
    run_instr(OP_R, 1'b0, 0, 0);
    build(OP_ST, 1'b0, 0, 3);
    tr = tr[0:2];
    run_trace(OP_ST, 1'b0);
    drive(1'b1, OP_ST, 1'b0);
    rst_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_v[0] = 1'b0;
    drive(1'b0, OP_ST, 1'b0);
    #1;
    n_checks++;
    if (obs_a !== f || cyc_a !== 32'd0 || ret_a !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_store got strb=%h cyc=%0d ret=%0d want strb=%h cyc=0 ret=0", obs_a, cyc_a, ret_a, f);
    end
    @(posedge clk);
    exp_cyc = 1; exp_ret = 0; exp_halt = 1'b0; exp_err = 1'b0;
    @(negedge clk);
    run_instr(OP_ST, 1'b0, 1, 2);
  endtask

  task automatic test_wrap();
    sel = 1; do_reset();
    repeat (17) run_instr(OP_NOP, 1'b0, 0, 0);
    n_checks++;
    if (ret_b !== 4'd1 || cyc_b !== 4'd2) begin
      n_fail++; $display("FAIL counter_wrap got ret=%0d cyc=%0d want ret=1 cyc=2", ret_b, cyc_b);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [11];
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_SYS, OP_NOP, 7'h7F, 7'b0001011};
    for (int s = 0; s < 2; s++) begin
      sel = s; do_reset();
      repeat (40) begin
        run_instr(ops[$urandom_range(0, 10)], 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0, $urandom_range(0, 5));
        if (exp_halt) begin
          run_halt(3);
          do_reset();
        end
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; sel = 0;
    exp_cyc = 0; exp_ret = 0; exp_halt = 1'b0; exp_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_load_stall();
    test_branch_jumps();
    test_ecall();
    test_timeout();
    test_reset_mid_store();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

endmodule
